core_reg_debug_port: RTL and testbench
======================================

Name: core_reg_debug_port

Overview:
- Debug read responder that answers register-file queries against the multicore processor, so checks like "core N, xK == value" run through a port, not hierarchical peeks.
- Accepts a request (core id, register index) on a valid/ready channel.
- Reads the selected core's register file through a dedicated debug read port, then returns the value on a valid/ready response channel.
- Instantiated in multicore_processor alongside core0..core3.

Parameters:
- NUM_CORES, 4, number of cores served (1..4).
- XLEN, 32, register data width.
- RD_LAT, 1, register-file debug read latency in cycles (1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_core  in  2  target core index.
- req_reg  in  5  target register index x0..x31.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  XLEN  register value.
- rsp_core  out  2  echo of req_core.
- rsp_reg  out  5  echo of req_reg.
- rsp_err  out  1  request targeted a nonexistent core.
- dbg_rd_en  out  NUM_CORES  one-hot read strobe per core.
- dbg_rd_addr  out  5  shared register address to all cores.
- dbg_rd_data  in  NUM_CORES*XLEN  flat read data; core i at bits [i*XLEN +: XLEN].

Behaviour:
- Reset values: req_ready=0 during rst, then 1 in IDLE. rsp_valid=0, rsp_data=0, rsp_core=0, rsp_reg=0, rsp_err=0, dbg_rd_en=0, dbg_rd_addr=0. FSM=IDLE, latency counter=0.
- Only one request is outstanding at a time. req_ready=1 only in IDLE. A request is accepted on the clk edge where req_valid && req_ready.
- FSM states:
  - IDLE:
    - On accept with req_core >= NUM_CORES: go to RESP; rsp_err=1, rsp_data=0; no dbg_rd_en pulse.
    - On accept with req_reg==0: go to RESP; rsp_data=0, rsp_err=0; no read issued.
    - Otherwise: latch core/reg, go to ISSUE.
  - ISSUE:
    - dbg_rd_en[core]=1 for exactly one cycle; dbg_rd_addr=latched reg.
    - Load counter with RD_LAT-1, go to WAIT.
  - WAIT:
    - If counter==0: capture dbg_rd_data slice of latched core into rsp_data, go to RESP.
    - Else decrement the counter.
    - dbg_rd_addr stays stable throughout WAIT.
  - RESP:
    - rsp_valid=1. rsp_data/core/reg/err are held constant until rsp_valid && rsp_ready.
    - On handshake: rsp_valid=0 next cycle, return to IDLE.
- Latency:
  - Normal read: accept edge to rsp_valid high = RD_LAT+2 cycles.
  - x0 or error request: 1 cycle.
- Throughput: when rsp_ready is tied high, a new request is accepted at most once every RD_LAT+3 cycles.
- dbg_rd_en is never asserted outside ISSUE and is always one-hot or zero.
- rsp_core/rsp_reg echo the accepted request, including for error responses.
- Back-to-back requests: req_valid held high during RESP is not accepted until IDLE is re-entered.
- A request fields change while req_ready=0 has no effect.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values. Any in-flight read is discarded, and no response is emitted for it.
- NUM_CORES<4: the unused high cores are error targets.

Optional Feature:
- Macro: CORE_DBG_CHECK_EN.
- Defined:
  - Adds input req_expect (XLEN) and output rsp_match (1).
  - req_expect is latched on accept.
  - rsp_match = (rsp_data == latched expect) && !rsp_err. It is valid with rsp_valid and resets to 0.
  - Adds a saturating 16-bit output mismatch_cnt, incremented on each response handshake with rsp_match=0. It resets to 0.
- Not defined: none of these ports or the comparison logic exist; all other behaviour is identical.

Test Plan:
- Preload core regs x3 = 15/27/7/42 for cores 0..3. Query (0,3), (1,3), (2,3), (3,3) with rsp_ready=1 → rsp_data = 15, 27, 7, 42. Each response arrives RD_LAT+2 cycles after accept; rsp_err=0.
- Query (2,0) → rsp_valid 1 cycle after accept with rsp_data=0; dbg_rd_en stays 0 throughout.
- NUM_CORES=2, query core 3 reg 5 → rsp_err=1, rsp_data=0, rsp_core=3, rsp_reg=5; no dbg_rd_en pulse.
- Hold rsp_ready=0 for 10 cycles after a (1,3) response → rsp_valid and rsp_data=27 stay stable; req_ready=0; a second request held on req_valid is accepted only after the handshake.
- Assert rst during WAIT of a (0,3) read → next cycle req_ready=1, rsp_valid=0, dbg_rd_en=0; no response ever appears for that read.
- With CORE_DBG_CHECK_EN: query (0,3) expect 15 → rsp_match=1; query (3,3) expect 41 → rsp_match=0, mismatch_cnt goes 0→1.

Source files
------------

// File: rtl/core_reg_debug_port.sv
// Debug read responder: answers (core, register) queries over a valid/ready channel by reading the
// selected core's register file through its debug read port. Define CORE_DBG_CHECK_EN for expected-value compare.
module core_reg_debug_port #(
   parameter int NUM_CORES = 4,
   parameter int XLEN      = 32,
   parameter int RD_LAT    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_core,
   input  logic [4:0]                req_reg,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [XLEN-1:0]           rsp_data,
   output logic [1:0]                rsp_core,
   output logic [4:0]                rsp_reg,
   output logic                      rsp_err,
   output logic [NUM_CORES-1:0]      dbg_rd_en,
   output logic [4:0]                dbg_rd_addr,
   input  logic [NUM_CORES*XLEN-1:0] dbg_rd_data
`ifdef CORE_DBG_CHECK_EN
   ,
   input  logic [XLEN-1:0]           req_expect,
   output logic                      rsp_match,
   output logic [15:0]               mismatch_cnt
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [2:0] CNT_LOAD    = 3'(RD_LAT - 1);
   localparam logic [2:0] NUM_CORES_W = 3'(NUM_CORES);

   function automatic logic [NUM_CORES-1:0] core_onehot(input logic [1:0] core);
      logic [NUM_CORES-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         oh[i] = (core == 2'(i));
      end
      return oh;
   endfunction

   logic [1:0]           state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [1:0]           core_q, core_d;
   logic [4:0]           reg_q, reg_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]      rsp_data_q, rsp_data_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [NUM_CORES-1:0] dbg_rd_en_q, dbg_rd_en_d;
   logic [4:0]           dbg_rd_addr_q, dbg_rd_addr_d;
   logic [XLEN-1:0]      rd_slice_s;
   logic                 bad_core_s;
`ifdef CORE_DBG_CHECK_EN
   logic [XLEN-1:0]      expect_q, expect_d;
   logic                 match_q, match_d;
   logic [15:0]          mm_cnt_q, mm_cnt_d;
`endif

   // Select the latched core's slice of the flat read-data bus.
   always_comb begin
      rd_slice_s = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         rd_slice_s = rd_slice_s | ({XLEN{core_q == 2'(i)}} & dbg_rd_data[i*XLEN +: XLEN]);
      end
   end

   assign bad_core_s = ({1'b0, req_core} >= NUM_CORES_W);

   // Next-state logic: one request in flight, x0 and missing cores answered without a read.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      core_d        = core_q;
      reg_d         = reg_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      dbg_rd_en_d   = dbg_rd_en_q;
      dbg_rd_addr_d = dbg_rd_addr_q;
`ifdef CORE_DBG_CHECK_EN
      expect_d      = expect_q;
      match_d       = match_q;
      mm_cnt_d      = mm_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               core_d     = req_core;
               reg_d      = req_reg;
               rsp_data_d = '0;
               rsp_err_d  = bad_core_s;
`ifdef CORE_DBG_CHECK_EN
               expect_d   = req_expect;
               match_d    = (req_expect == '0) && !bad_core_s;
`endif
               if (bad_core_s || (req_reg == 5'd0)) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d       = ST_ISSUE;
                  dbg_rd_en_d   = core_onehot(req_core);
                  dbg_rd_addr_d = req_reg;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            dbg_rd_en_d = '0;
            cnt_d       = CNT_LOAD;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            // Count reaches zero in the cycle the register file presents its data.
            if (cnt_q == 3'd0) begin
               rsp_data_d  = rd_slice_s;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
`ifdef CORE_DBG_CHECK_EN
               match_d     = (rd_slice_s == expect_q);
`endif
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
`ifdef CORE_DBG_CHECK_EN
               if (!match_q && (mm_cnt_q != 16'hFFFF)) begin
                  mm_cnt_d = mm_cnt_q + 16'd1;
               end else begin
                  mm_cnt_d = mm_cnt_q;
               end
`endif
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            dbg_rd_en_d = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 3'd0;
         core_q        <= 2'd0;
         reg_q         <= 5'd0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
         dbg_rd_en_q   <= '0;
         dbg_rd_addr_q <= 5'd0;
`ifdef CORE_DBG_CHECK_EN
         expect_q      <= '0;
         match_q       <= 1'b0;
         mm_cnt_q      <= 16'd0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         core_q        <= core_d;
         reg_q         <= reg_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         dbg_rd_en_q   <= dbg_rd_en_d;
         dbg_rd_addr_q <= dbg_rd_addr_d;
`ifdef CORE_DBG_CHECK_EN
         expect_q      <= expect_d;
         match_q       <= match_d;
         mm_cnt_q      <= mm_cnt_d;
`endif
      end
   end

   assign req_ready   = (state_q == ST_IDLE) && !rst;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_core    = core_q;
   assign rsp_reg     = reg_q;
   assign rsp_err     = rsp_err_q;
   assign dbg_rd_en   = dbg_rd_en_q;
   assign dbg_rd_addr = dbg_rd_addr_q;
`ifdef CORE_DBG_CHECK_EN
   assign rsp_match    = match_q;
   assign mismatch_cnt = mm_cnt_q;
`endif

endmodule

// File: tb/tb_core_reg_debug_port.sv
// Self-checking bench for core_reg_debug_port: a 4-core/RD_LAT=2 instance with a register-file model,
// plus a 2-core/RD_LAT=1 instance for the missing-core error path.
module tb_core_reg_debug_port;

   localparam int A_NC = 4;
   localparam int A_LAT = 2;
   localparam int B_NC = 2;
   localparam int B_LAT = 1;

   typedef struct {
      logic [1:0]  core;
      logic [4:0]  rg;
      int          hold;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
   logic [1:0]  req_core = 2'd0;
   logic [4:0]  req_reg = 5'd0;
   logic        a_rsp_ready = 1'b0;
   logic        a_req_ready, a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_data;
   logic [1:0]  a_rsp_core;
   logic [4:0]  a_rsp_reg, a_dbg_rd_addr;
   logic [3:0]  a_dbg_rd_en;
   logic [127:0] a_dbg_rd_data;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_data;
   logic [1:0]  b_rsp_core;
   logic [4:0]  b_rsp_reg, b_dbg_rd_addr;
   logic [1:0]  b_dbg_rd_en;
   logic [63:0] b_dbg_rd_data;
`ifdef CORE_DBG_CHECK_EN
   logic [31:0] req_expect = 32'd0;
   logic        a_rsp_match, b_rsp_match;
   logic [15:0] a_mm_cnt, b_mm_cnt;
   int          mm_model = 0;
`endif

   core_reg_debug_port #(.NUM_CORES(A_NC), .XLEN(32), .RD_LAT(A_LAT)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(a_req_ready),
      .req_core(req_core), .req_reg(req_reg), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_data(a_rsp_data), .rsp_core(a_rsp_core), .rsp_reg(a_rsp_reg), .rsp_err(a_rsp_err),
      .dbg_rd_en(a_dbg_rd_en), .dbg_rd_addr(a_dbg_rd_addr), .dbg_rd_data(a_dbg_rd_data)
`ifdef CORE_DBG_CHECK_EN
      , .req_expect(req_expect), .rsp_match(a_rsp_match), .mismatch_cnt(a_mm_cnt)
`endif
   );

   core_reg_debug_port #(.NUM_CORES(B_NC), .XLEN(32), .RD_LAT(B_LAT)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(b_req_ready),
      .req_core(req_core), .req_reg(req_reg), .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
      .rsp_data(b_rsp_data), .rsp_core(b_rsp_core), .rsp_reg(b_rsp_reg), .rsp_err(b_rsp_err),
      .dbg_rd_en(b_dbg_rd_en), .dbg_rd_addr(b_dbg_rd_addr), .dbg_rd_data(b_dbg_rd_data)
`ifdef CORE_DBG_CHECK_EN
      , .req_expect(req_expect), .rsp_match(b_rsp_match), .mismatch_cnt(b_mm_cnt)
`endif
   );

   // Register-file model: contents array, RD_LAT-deep read pipeline, garbage when not strobed.
   logic [31:0] regs [A_NC][32];
   logic [31:0] pipe0 [A_NC];
   logic [31:0] pipe1 [A_NC];
   logic [31:0] b_pipe [B_NC];
   int          a_pulses = 0, a_bad_en = 0, b_pulses = 0;
   logic [3:0]  a_last_en = 4'd0;
   logic [4:0]  a_last_addr = 5'd0;

   always @(posedge clk) begin
      for (int i = 0; i < A_NC; i++) begin
         pipe0[i] <= a_dbg_rd_en[i] ? regs[i][a_dbg_rd_addr] : $urandom();
         pipe1[i] <= pipe0[i];
      end
      for (int i = 0; i < B_NC; i++) begin
         b_pipe[i] <= b_dbg_rd_en[i] ? (32'((i + 1) * 256) + {27'd0, b_dbg_rd_addr}) : 32'hDEAD_BEEF;
      end
      if (a_dbg_rd_en != 4'd0) begin
         a_pulses    <= a_pulses + 1;
         a_last_en   <= a_dbg_rd_en;
         a_last_addr <= a_dbg_rd_addr;
         if ($countones(a_dbg_rd_en) != 1) a_bad_en <= a_bad_en + 1;
      end
      if (b_dbg_rd_en != 2'd0) b_pulses <= b_pulses + 1;
   end

   for (genvar g = 0; g < A_NC; g++) begin : g_a_data
      assign a_dbg_rd_data[g*32 +: 32] = pipe1[g];
   end
   for (genvar g = 0; g < B_NC; g++) begin : g_b_data
      assign b_dbg_rd_data[g*32 +: 32] = b_pipe[g];
   end

   int tests = 0;
   int failed = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request on instance A; hold = cycles with rsp_ready low; keep = leave a (0,3) request pending.
   task automatic a_txn(input logic [1:0] c, input logic [4:0] r, input int hold,
                        input logic [31:0] exp_d, input logic exp_e, input bit keep, input string nm);
      int   n, lat, p0, exp_lat, exp_p;
      bit   stable;
`ifdef CORE_DBG_CHECK_EN
      logic [31:0] exp_sv;
      logic        exp_m;
`endif
      exp_lat = (exp_e || r == 5'd0) ? 1 : A_LAT + 2;
      exp_p   = (exp_e || r == 5'd0) ? 0 : 1;
      req_core = c; req_reg = r; req_valid_a = 1'b1; a_rsp_ready = (hold == 0);
`ifdef CORE_DBG_CHECK_EN
      req_expect = ($urandom_range(0, 1) == 1) ? exp_d : (exp_d ^ 32'h1);
      exp_sv = req_expect;
      exp_m  = (exp_sv == exp_d) && !exp_e;
`endif
      n = 0;
      while (!a_req_ready && n < 50) begin tick(); n++; end
      chk({nm, " accept"}, 64'(a_req_ready), 64'd1);
      p0 = a_pulses;
      tick();
      if (keep) begin
         req_core = 2'd0; req_reg = 5'd3;
      end else begin
         req_valid_a = 1'b0; req_core = 2'($urandom()); req_reg = 5'($urandom());
      end
`ifdef CORE_DBG_CHECK_EN
      req_expect = $urandom();
`endif
      lat = 1;
      while (!a_rsp_valid && lat < 40) begin tick(); lat++; end
      chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, " data"}, 64'(a_rsp_data), 64'(exp_d));
      chk({nm, " err"}, 64'(a_rsp_err), 64'(exp_e));
      chk({nm, " core/reg"}, 64'({a_rsp_core, a_rsp_reg}), 64'({c, r}));
`ifdef CORE_DBG_CHECK_EN
      chk({nm, " match"}, 64'(a_rsp_match), 64'(exp_m));
`endif
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         if (!a_rsp_valid || a_rsp_data !== exp_d || a_req_ready || a_rsp_core !== c) stable = 1'b0;
         tick();
      end
      if (hold > 0) chk({nm, " hold stable"}, 64'(stable), 64'd1);
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
      chk({nm, " rsp_valid drop"}, 64'(a_rsp_valid), 64'd0);
      chk({nm, " rd pulses"}, 64'(a_pulses - p0), 64'(exp_p));
      if (exp_p == 1) chk({nm, " rd en/addr"}, 64'({a_last_en, a_last_addr}), 64'({4'b0001 << c, r}));
`ifdef CORE_DBG_CHECK_EN
      if (!exp_m) mm_model++;
      chk({nm, " mismatch_cnt"}, 64'(a_mm_cnt), 64'(mm_model));
`endif
   endtask

   // One request on instance B (rsp_ready tied high).
   task automatic b_txn(input logic [1:0] c, input logic [4:0] r,
                        input logic [31:0] exp_d, input logic exp_e, input string nm);
      int lat, p0, exp_lat;
      exp_lat = (exp_e || r == 5'd0) ? 1 : B_LAT + 2;
      chk({nm, " idle ready"}, 64'(b_req_ready), 64'd1);
      req_core = c; req_reg = r; req_valid_b = 1'b1;
      p0 = b_pulses;
      tick();
      req_valid_b = 1'b0;
      lat = 1;
      while (!b_rsp_valid && lat < 40) begin tick(); lat++; end
      chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, " data/err"}, 64'({b_rsp_data, b_rsp_err}), 64'({exp_d, exp_e}));
      chk({nm, " core/reg"}, 64'({b_rsp_core, b_rsp_reg}), 64'({c, r}));
      tick();
      chk({nm, " rd pulses"}, 64'(b_pulses - p0), 64'((exp_e || r == 5'd0) ? 0 : 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [7];
      bit   seen;
      logic [1:0]  rc;
      logic [4:0]  rr;

      for (int i = 0; i < A_NC; i++)
         for (int j = 0; j < 32; j++) regs[i][j] = $urandom() | 32'h1;
      regs[0][3] = 32'd15; regs[1][3] = 32'd27; regs[2][3] = 32'd7; regs[3][3] = 32'd42;
      regs[3][31] = 32'hCAFE_F00D;

      vecs[0] = '{2'd0, 5'd3,  0, 32'd15, 1'b0};
      vecs[1] = '{2'd1, 5'd3,  0, 32'd27, 1'b0};
      vecs[2] = '{2'd2, 5'd3,  0, 32'd7,  1'b0};
      vecs[3] = '{2'd3, 5'd3,  0, 32'd42, 1'b0};
      vecs[4] = '{2'd2, 5'd0,  0, 32'd0,  1'b0};
      vecs[5] = '{2'd1, 5'd3,  4, 32'd27, 1'b0};
      vecs[6] = '{2'd3, 5'd31, 2, 32'hCAFE_F00D, 1'b0};

      repeat (3) tick();
      chk("reset req_ready", 64'(a_req_ready), 64'd0);
      chk("reset rsp", 64'({a_rsp_valid, a_rsp_err, a_rsp_core, a_rsp_reg}), 64'd0);
      chk("reset rsp_data", 64'(a_rsp_data), 64'd0);
      chk("reset dbg", 64'({a_dbg_rd_en, a_dbg_rd_addr}), 64'd0);
      rst = 1'b0;
      #1;
      chk("idle req_ready", 64'(a_req_ready), 64'd1);

      for (int i = 0; i < 7; i++)
         a_txn(vecs[i].core, vecs[i].rg, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_err, 1'b0,
               $sformatf("vec%0d", i));

      // Back-to-back: second request held while the first response is stalled for 10 cycles.
      a_txn(2'd1, 5'd3, 10, 32'd27, 1'b0, 1'b1, "stall");
      a_txn(2'd0, 5'd3, 0, 32'd15, 1'b0, 1'b0, "after_stall");

      // Reset during WAIT of a (0,3) read: read discarded, no response.
      req_core = 2'd0; req_reg = 5'd3; req_valid_a = 1'b1;
      tick();
      req_valid_a = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_wait req_ready", 64'(a_req_ready), 64'd1);
      chk("rst_wait outputs", 64'({a_rsp_valid, a_dbg_rd_en, a_rsp_err}), 64'd0);
      chk("rst_wait rsp_data", 64'(a_rsp_data), 64'd0);
      seen = 1'b0;
      repeat (12) begin
         if (a_rsp_valid) seen = 1'b1;
         tick();
      end
      chk("rst_wait no response", 64'(seen), 64'd0);
`ifdef CORE_DBG_CHECK_EN
      mm_model = 0;
`endif

      // Randomized traffic against the contents model.
      for (int i = 0; i < 40; i++) begin
         rc = 2'($urandom_range(0, 3));
         rr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         a_txn(rc, rr, $urandom_range(0, 3), (rr == 5'd0) ? 32'd0 : regs[rc][rr], 1'b0, 1'b0,
               $sformatf("rnd%0d", i));
      end

      // Two-core instance: cores 2 and 3 do not exist.
      b_txn(2'd3, 5'd5, 32'd0, 1'b1, "b_err3");
      b_txn(2'd2, 5'd7, 32'd0, 1'b1, "b_err2");
      b_txn(2'd1, 5'd4, 32'h204, 1'b0, "b_rd1");
      b_txn(2'd0, 5'd9, 32'h109, 1'b0, "b_rd0");
      b_txn(2'd1, 5'd0, 32'd0, 1'b0, "b_x0");

      chk("dbg_rd_en one-hot", 64'(a_bad_en), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
